slc3_mem_arbiter: RTL and testbench
===================================

// Module: slc3_mem_arbiter
// PURPOSE
//  Shares the single 16-bit SRAM port between the SLC-3 CPU and the memory-init loader.
//  Sequences each access with a fixed wait-state count and returns a one-cycle ready pulse.
//  Optionally decodes the memory-mapped I/O word at 0xFFFF: read returns SW, write loads the hex register.
//  Sits between the CPU memory interface and the top-level SRAM pins.
// PARAMETERS
//  WAIT_CYCLES  2   cycles SRAM strobes are held per access; legal range >= 1
//  AW           16  address width, CPU and loader
//  DW           16  data width
// PORTS
//  Clk        in   1   system clock, all state on rising edge
//  Reset      in   1   synchronous, active-high
//  cpu_req    in   1   CPU access request; held until cpu_ready
//  cpu_we     in   1   1=write, 0=read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_rdata  out  DW  read data, valid while cpu_ready=1, held after
//  cpu_ready  out  1   one-cycle completion pulse to CPU
//  ld_req     in   1   loader write request (loader only writes)
//  ld_addr    in   AW  loader address
//  ld_wdata   in   DW  loader write data
//  ld_ready   out  1   one-cycle completion pulse to loader
//  sram_ce_n  out  1   SRAM chip enable, active low
//  sram_oe_n  out  1   SRAM output enable, active low
//  sram_we_n  out  1   SRAM write enable, active low
//  sram_addr  out  AW  SRAM address
//  sram_wdata out  DW  SRAM write data
//  sram_rdata in   DW  SRAM read data
//  SW         in   10  board switches (I/O read source)
//  hex_out    out  16  hex display register (I/O write target)
// BEHAVIOUR
//  Reset: state IDLE; cpu_ready=ld_ready=0; sram_ce_n/oe_n/we_n=1; sram_addr=0;
//   sram_wdata=0; cpu_rdata=0; hex_out=0. A Reset mid-access aborts it: strobes go high at that edge, no ready pulse.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: requests are sampled only here. ld_req beats cpu_req (absolute priority).
//   On grant, latch the owner, we, addr and wdata, load wait_cnt=WAIT_CYCLES-1, go to ACCESS.
//  ACCESS: ce_n=0; read: oe_n=0, we_n=1; write: we_n=0, oe_n=1.
//   Address and data stay stable throughout. Decrement wait_cnt.
//   When wait_cnt==0, capture sram_rdata (reads) into cpu_rdata and go to DONE.
//  DONE: all strobes=1; the owner's ready=1 for exactly this cycle; go to IDLE.
//  Latency: req sampled in IDLE at cycle N -> ready high in cycle N+WAIT_CYCLES+1.
//  A req still high in the cycle after ready counts as a new request. Back-to-back period is WAIT_CYCLES+2 cycles.
//  Simultaneous ld_req and cpu_req: loader is served first; the CPU is served on the next IDLE if ld_req is low then.
//  Changes to req, addr or data after grant are ignored until ready.
//  An address at AW max wraps nowhere: no increment is performed here.
// CONFIGURATION
//  SLC3_IO_MAP_EN defined: a CPU access to 0xFFFF bypasses SRAM (strobes stay high).
//   Read: cpu_rdata={6'b0,SW}. Write: hex_out<=cpu_wdata. Path is IDLE->DONE, so ready comes in cycle N+1.
//   Loader accesses to 0xFFFF still go to SRAM.
//  SLC3_IO_MAP_EN undefined: 0xFFFF is ordinary SRAM. hex_out holds 0. SW is unused.
// STRUCTURE
//  Package slc3_mem_pkg: state enum {IDLE,ACCESS,DONE}, owner enum {OWN_CPU,OWN_LD},
//   constant IO_ADDR=16'hFFFF.
//  Sub-module slc3_mem_io_port holds the hex_out register and the SW read mux.
//   It is instantiated only under SLC3_IO_MAP_EN.
//  Elaboration assertion: WAIT_CYCLES>=1.
// TESTING
//  1. CPU read 0x0010 (SRAM model returns 0x1234), WAIT_CYCLES=2 -> oe_n low 2 cycles; cpu_ready at N+3; cpu_rdata=0x1234.
//  2. CPU write 0x0020<=0xBEEF -> we_n low 2 cycles; addr/wdata stable; model holds 0xBEEF; one-cycle cpu_ready.
//  3. ld_req and cpu_req in the same cycle -> ld_ready first.
//   The CPU access starts on the IDLE after DONE; cpu_ready arrives WAIT_CYCLES+2 cycles after ld_ready.
//  4. IO_MAP_EN, SW=10'h014, CPU read 0xFFFF -> ready at N+1, cpu_rdata=0x0014, ce_n never low.
//   Then CPU write 0xFFFF<=0x00A5 -> hex_out=0x00A5.
//  5. Reset asserted in the 2nd ACCESS cycle -> next edge: strobes high, no ready pulse, state IDLE; a new request completes normally.
//  6. cpu_req held high across ready -> second access granted on the next IDLE; ready pulses are spaced WAIT_CYCLES+2 apart.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory arbiter.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

  // Memory-mapped I/O word (switches on read, hex display on write).
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/slc3_mem_arbiter_if.sv
// Bus bundle between the CPU, the memory-init loader, the SRAM pins and the board I/O.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface slc3_mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);

  // CPU side
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  // Loader side (write only)
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ready;

  // SRAM pins
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  // Board I/O
  logic [9:0]    SW;
  logic [15:0]   hex_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  ld_req, ld_addr, ld_wdata,
    output ld_ready,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_addr, sram_wdata,
    input  sram_rdata,
    input  SW,
    output hex_out
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output ld_req, ld_addr, ld_wdata,
    input  ld_ready,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_addr, sram_wdata,
    output sram_rdata,
    output SW,
    input  hex_out
  );

endinterface

// File: rtl/slc3_mem_io_port.sv
// Memory-mapped I/O word: hex display register (write) and switch read mux (read).
// Only instantiated when SLC3_IO_MAP_EN is defined.
module slc3_mem_io_port #(
  parameter int unsigned DW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [9:0]    sw_i,
  output logic [15:0]   hex_o,
  output logic [DW-1:0] rdata_o
);

  logic [15:0] hex_q;

  // Hex display register, loaded by a CPU write to the I/O word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_q <= 16'h0000;
    end else if (wr_en_i) begin
      hex_q <= wdata_i[15:0];
    end
  end

  assign hex_o   = hex_q;
  assign rdata_o = DW'({6'b000000, sw_i});

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Shares the single SRAM port between the SLC-3 CPU and the memory-init loader.
// Each access holds the SRAM strobes for WAIT_CYCLES cycles, then pulses the owner's ready.
// The loader has absolute priority; requests are sampled only in IDLE.
// Optional feature: define SLC3_IO_MAP_EN to decode CPU accesses to 0xFFFF as board I/O
// (read returns the switches, write loads the hex register) without touching the SRAM.
module slc3_mem_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16
) (
  input logic              Clk,
  input logic              Reset,
  slc3_mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("slc3_mem_arbiter: WAIT_CYCLES must be >= 1");
  end

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;

`ifdef SLC3_IO_MAP_EN
  logic          io_hit;
  logic          io_wr;
  logic [DW-1:0] io_rdata;

  assign io_hit = (bus.cpu_addr == AW'(IO_ADDR));

  slc3_mem_io_port #(
    .DW(DW)
  ) u_io_port (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_en_i (io_wr),
    .wdata_i (bus.cpu_wdata),
    .sw_i    (bus.SW),
    .hex_o   (bus.hex_out),
    .rdata_o (io_rdata)
  );
`else
  assign bus.hex_out = 16'h0000;
`endif

  // Next-state: grant in IDLE (loader first), count wait states in ACCESS, one DONE cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef SLC3_IO_MAP_EN
    io_wr   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.ld_req) begin
          owner_d = OWN_LD;
          we_d    = 1'b1;
          addr_d  = bus.ld_addr;
          wdata_d = bus.ld_wdata;
          cnt_d   = CntLoad;
          state_d = ACCESS;
        end else if (bus.cpu_req) begin
          owner_d = OWN_CPU;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          cnt_d   = CntLoad;
          state_d = ACCESS;
`ifdef SLC3_IO_MAP_EN
          // I/O word bypasses the SRAM entirely and completes in one cycle.
          if (io_hit) begin
            state_d = DONE;
            if (bus.cpu_we) begin
              io_wr = 1'b1;
            end else begin
              rdata_d = io_rdata;
            end
          end
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rdata_d = bus.sram_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched transaction registers; Reset aborts any access in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes are decoded from the state, so they rise on the same edge that leaves ACCESS.
  assign bus.sram_ce_n  = (state_q != ACCESS);
  assign bus.sram_oe_n  = !((state_q == ACCESS) && !we_q);
  assign bus.sram_we_n  = !((state_q == ACCESS) && we_q);
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;

  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_ready  = (state_q == DONE) && (owner_q == OWN_CPU);
  assign bus.ld_ready   = (state_q == DONE) && (owner_q == OWN_LD);

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Scoreboard bench for slc3_mem_arbiter: a driver issues transactions and pushes the expected
// completions; a monitor pops and compares whenever a ready pulse appears.
module tb_slc3_mem_arbiter;

  localparam int unsigned W = 2;

  logic Clk;
  logic Reset;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  slc3_mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  slc3_mem_arbiter #(
    .WAIT_CYCLES (W),
    .AW          (16),
    .DW          (16)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b0;
  bit expect_abort = 1'b0;

  typedef struct {
    bit          is_ld;
    bit          we;
    bit          io;
    logic [15:0] addr;
    logic [15:0] data;
    int          rdy_cyc;
    int          strobes;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] ref_mem [int];
  logic [15:0] sram_mem [0:65535];
  logic [15:0] exp_hold = 16'h0;
  logic [15:0] exp_hex = 16'h0;
  int          strobe_cnt = 0;

  always @(posedge Clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= Reset;
  end

  // SRAM model
  always @(posedge Clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_wdata;
  end

  always_comb begin
    bus.sram_rdata = 16'hDEAD;
    if (!bus.sram_oe_n) bus.sram_rdata = sram_mem[bus.sram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 16'hFFFF;
    return 16'($urandom_range(0, 31));
  endfunction

  // Reference model: loader write sampled in cycle s.
  task automatic push_ld(input logic [15:0] a, input logic [15:0] d, input int s);
    exp_t e;
    e.is_ld = 1'b1; e.we = 1'b1; e.io = 1'b0; e.addr = a; e.data = d;
    e.rdy_cyc = s + W + 1; e.strobes = W;
    ref_mem[int'(a)] = d;
    sb_q.push_back(e);
  endtask

  // Reference model: CPU access sampled in cycle s.
  task automatic push_cpu(input bit we, input logic [15:0] a, input logic [15:0] d, input int s);
    exp_t e;
    e.is_ld = 1'b0; e.we = we; e.addr = a;
`ifdef SLC3_IO_MAP_EN
    e.io = (a == 16'hFFFF);
`else
    e.io = 1'b0;
`endif
    if (e.io) begin
      e.rdy_cyc = s + 1;
      e.strobes = 0;
      e.data    = we ? d : {6'b0, bus.SW};
    end else begin
      e.rdy_cyc = s + W + 1;
      e.strobes = W;
      if (we) begin
        ref_mem[int'(a)] = d;
        e.data = d;
      end else begin
        e.data = ref_rd(a);
      end
    end
    sb_q.push_back(e);
  endtask

  // Monitor
  always @(negedge Clk) begin
    exp_t e;
    if (rst_at_edge) begin
      strobe_cnt = 0;
      exp_hold   = 16'h0;
      exp_hex    = 16'h0;
    end else begin
      if (!bus.sram_ce_n) begin
        strobe_cnt++;
        if (sb_q.size() == 0) begin
          if (!expect_abort) chk("strobe_without_txn", 32'(bus.sram_ce_n), 32'(1));
        end else begin
          e = sb_q[0];
          chk("sram_addr", 32'(bus.sram_addr), 32'(e.addr));
          chk("sram_oe_we", 32'({bus.sram_oe_n, bus.sram_we_n}), e.we ? 32'(2'b10) : 32'(2'b01));
          if (e.we) chk("sram_wdata", 32'(bus.sram_wdata), 32'(e.data));
        end
      end else begin
        chk("idle_strobes", 32'({bus.sram_oe_n, bus.sram_we_n}), 32'(2'b11));
      end
      if (bus.cpu_ready || bus.ld_ready) begin
        if (sb_q.size() == 0) begin
          chk("ready_without_txn", 32'({bus.ld_ready, bus.cpu_ready}), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("ready_owner", 32'({bus.ld_ready, bus.cpu_ready}), e.is_ld ? 32'(2'b10) : 32'(2'b01));
          chk("ready_cycle", 32'(cyc), 32'(e.rdy_cyc));
          chk("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
          if (!e.is_ld && !e.we) exp_hold = e.data;
          if (!e.is_ld && e.io && e.we) exp_hex = e.data;
        end
        strobe_cnt = 0;
      end
      chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_hold));
      chk("hex_out", 32'(bus.hex_out), 32'(exp_hex));
    end
  end

  task automatic do_txn(input bit use_ld, input bit use_cpu, input bit c_we,
                        input logic [15:0] c_addr, input logic [15:0] c_wdata,
                        input logic [15:0] l_addr, input logic [15:0] l_wdata,
                        input bit scramble);
    bit pend_ld, pend_cpu;
    int t;
    @(negedge Clk);
    if (use_ld) begin
      bus.ld_req = 1'b1; bus.ld_addr = l_addr; bus.ld_wdata = l_wdata;
      push_ld(l_addr, l_wdata, cyc);
    end
    if (use_cpu) begin
      bus.cpu_req = 1'b1; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wdata;
      push_cpu(c_we, c_addr, c_wdata, use_ld ? cyc + W + 2 : cyc);
    end
    pend_ld = use_ld;
    pend_cpu = use_cpu;
    t = 0;
    while ((pend_ld || pend_cpu) && t < 50) begin
      @(negedge Clk);
      t++;
      if (bus.ld_ready) begin bus.ld_req = 1'b0; pend_ld = 1'b0; end
      if (bus.cpu_ready) begin bus.cpu_req = 1'b0; pend_cpu = 1'b0; end
      // Disturb the granted requester's inputs; the latched values must win.
      if (scramble && t == 1) begin
        if (use_ld && pend_ld) begin
          bus.ld_addr = 16'($urandom); bus.ld_wdata = 16'($urandom);
        end else if (!use_ld && pend_cpu) begin
          bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 16'($urandom); bus.cpu_we = ~bus.cpu_we;
        end
      end
    end
    if (pend_ld || pend_cpu) begin
      checks++; errors++;
      $display("FAIL txn_timeout: pending ld=%0d cpu=%0d after %0d cycles", pend_ld, pend_cpu, t);
      bus.ld_req = 1'b0; bus.cpu_req = 1'b0;
      sb_q.delete();
    end
  endtask

  // CPU keeps cpu_req high across each ready, presenting the next access immediately.
  task automatic cpu_burst(input int n);
    int i, t;
    bit pend;
    logic [15:0] a, d;
    bit we;
    @(negedge Clk);
    a = rand_addr(); d = 16'($urandom); we = bit'($urandom_range(0, 1));
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    push_cpu(we, a, d, cyc);
    i = 1; t = 0; pend = 1'b1;
    while (pend && t < 100) begin
      @(negedge Clk);
      t++;
      if (bus.cpu_ready) begin
        if (i < n) begin
          a = rand_addr(); d = 16'($urandom); we = bit'($urandom_range(0, 1));
          bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
          push_cpu(we, a, d, cyc + 1);
          i++;
        end else begin
          bus.cpu_req = 1'b0;
          pend = 1'b0;
        end
      end
    end
    if (pend) begin
      checks++; errors++;
      $display("FAIL burst_timeout: %0d of %0d done", i - 1, n);
      bus.cpu_req = 1'b0;
      sb_q.delete();
    end
  endtask

  // Reset in the 2nd ACCESS cycle of a CPU read: strobes drop, no ready, outputs cleared.
  task automatic reset_abort();
    @(negedge Clk);
    expect_abort = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0005;
    @(negedge Clk);
    chk("abort_ce_active", 32'(bus.sram_ce_n), 32'(0));
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_ce_n", 32'(bus.sram_ce_n), 32'(1));
    chk("abort_oe_n", 32'(bus.sram_oe_n), 32'(1));
    chk("abort_ready", 32'({bus.ld_ready, bus.cpu_ready}), 32'(0));
    chk("abort_rdata", 32'(bus.cpu_rdata), 32'(0));
    Reset = 1'b0;
    bus.cpu_req = 1'b0;
    expect_abort = 1'b0;
  endtask

  initial begin
    int kind;
    bit scr;
    for (int i = 0; i < 65536; i++) sram_mem[i] = 16'(i) ^ 16'h5A5A;
    Reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.SW = 10'h000;
    repeat (3) @(negedge Clk);
    chk("rst_ready", 32'({bus.ld_ready, bus.cpu_ready}), 32'(0));
    chk("rst_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}), 32'(3'b111));
    chk("rst_sram_addr", 32'(bus.sram_addr), 32'(0));
    chk("rst_sram_wdata", 32'(bus.sram_wdata), 32'(0));
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
    chk("rst_hex_out", 32'(bus.hex_out), 32'(0));
    Reset = 1'b0;

    // Loader preload then CPU read of 0x0010.
    do_txn(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0010, 16'h1234, 1'b0);
    do_txn(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0, 16'h0, 1'b0);
    // CPU write 0x0020 <= 0xBEEF, read back with input scrambling.
    do_txn(1'b0, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0, 16'h0, 1'b1);
    do_txn(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h0, 16'h0, 1'b0);
    // Simultaneous requests: loader first, CPU sees its write.
    do_txn(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 16'h0030, 16'h5555, 1'b1);
    // I/O word: loader still hits SRAM; CPU read/write decoded if the map is enabled.
    bus.SW = 10'h014;
    do_txn(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'hFFFF, 16'h7777, 1'b0);
    do_txn(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b0);
    do_txn(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h00A5, 16'h0, 16'h0, 1'b0);
    do_txn(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b0);
    // Reset mid-access, then a normal read.
    reset_abort();
    do_txn(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0, 16'h0, 16'h0, 1'b0);
    // Held request across ready.
    cpu_burst(3);

    for (int i = 0; i < 60; i++) begin
      bus.SW = 10'($urandom);
      kind = $urandom_range(0, 3);
      scr = bit'($urandom_range(0, 1));
      case (kind)
        0: do_txn(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, rand_addr(), 16'($urandom), scr);
        1: do_txn(1'b0, 1'b1, bit'($urandom_range(0, 1)), rand_addr(), 16'($urandom),
                  16'h0, 16'h0, scr);
        2: do_txn(1'b1, 1'b1, bit'($urandom_range(0, 1)), rand_addr(), 16'($urandom),
                  rand_addr(), 16'($urandom), scr);
        default: cpu_burst(2 + $urandom_range(0, 1));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (5) @(negedge Clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
